// File: rtl/cic_dec_core_pkg.sv
// Shared CIC constants and helpers used by the decimator core, the shifter
// and the interpolator counterpart.
package cic_pkg;

    localparam int N                = 4;
    localparam int log2_of_max_rate = 7;
    localparam int maxbitgain       = N * log2_of_max_rate;
    localparam int max_rate         = 1 << log2_of_max_rate;

    // Full-precision datapath width for a given input sample width.
    function automatic int cic_width(input int bw);
        return bw + maxbitgain;
    endfunction

    // Clamp a programmed rate into the supported 1..max_rate range.
    function automatic logic [7:0] eff_rate(input logic [7:0] rate);
        if (rate == 8'd0)
            return 8'd1;
        else if (rate > 8'(max_rate))
            return 8'(max_rate);
        else
            return rate;
    endfunction

endpackage

// File: rtl/cic_dec_core_if.sv
// Sample-stream bus of the CIC decimator core: control, input strobe/sample
// and full-precision output strobe/sample.
interface cic_dec_core_if
    import cic_pkg::*;
#(
    parameter int bw = 16
);

    localparam int W = cic_width(bw);

    logic          enable;
    logic [7:0]    rate;
    logic          strobe_in;
    logic [bw-1:0] signal_in;
    logic          strobe_out;
    logic [W-1:0]  signal_out;

    modport master (
        output enable, rate, strobe_in, signal_in,
        input  strobe_out, signal_out
    );

    modport slave (
        input  enable, rate, strobe_in, signal_in,
        output strobe_out, signal_out
    );

endinterface

// File: rtl/cic_dec_core_comb_stage.sv
// One CIC comb (differentiator) stage running at the decimated rate.
// Wraps modulo 2**width; wrap introduced by the integrators cancels here.
module cic_comb_stage #(
    parameter int width = 44
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [width-1:0] x,
    output logic [width-1:0] y
);

    logic [width-1:0] dly;

    // Difference between the current and the previous decimated input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
            y   <= '0;
        end else if (clear) begin
            dly <= '0;
            y   <= '0;
        end else if (en) begin
            y   <= x - dly;
            dly <= x;
        end
    end

endmodule

// File: rtl/cic_dec_core.sv
// Integrator/comb core of the receive CIC decimator: N integrators at the
// input strobe rate, runtime decimation by 1..128, N combs at the output
// rate. Output is full precision; bit growth is removed downstream.
module cic_dec_core
    import cic_pkg::*;
#(
    parameter int bw = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    cic_dec_core_if.slave bus
);

    localparam int W = cic_width(bw);

    logic [W-1:0]        sig_ext;
    logic [N-1:0][W-1:0] integ;
    logic [7:0]          count;
    logic                strobe_dec;
    logic                strobe_dly;
    logic [W-1:0]        comb_chain [N+1];

    assign sig_ext = {{(W-bw){bus.signal_in[bw-1]}}, bus.signal_in};

    // Integrator cascade; each stage adds the previous stage's registered value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            integ <= '0;
        end else if (!bus.enable) begin
            integ <= '0;
        end else if (bus.strobe_in) begin
            integ[0] <= integ[0] + sig_ext;
            for (int i = 1; i < N; i++)
                integ[i] <= integ[i] + integ[i-1];
        end
    end

    // Decimation counter; rate is only looked at on reload so a change
    // mid-period lets the current period finish at the old rate.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            strobe_dec <= 1'b0;
        end else if (!bus.enable) begin
            count      <= '0;
            strobe_dec <= 1'b0;
        end else begin
            strobe_dec <= 1'b0;
            if (bus.strobe_in) begin
                if (count == 8'd0) begin
                    count      <= eff_rate(bus.rate) - 8'd1;
                    strobe_dec <= 1'b1;
                end else begin
                    count <= count - 8'd1;
                end
            end
        end
    end

    // Output strobe lines up with the cycle the last comb stage updates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            strobe_dly <= 1'b0;
        else if (!bus.enable)
            strobe_dly <= 1'b0;
        else
            strobe_dly <= strobe_dec;
    end

    assign comb_chain[0] = integ[N-1];

    for (genvar i = 0; i < N; i++) begin : g_comb
        cic_comb_stage #(
            .width (W)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (!bus.enable),
            .en      (strobe_dec),
            .x       (comb_chain[i]),
            .y       (comb_chain[i+1])
        );
    end

    assign bus.strobe_out = strobe_dly;
    assign bus.signal_out = comb_chain[N];

endmodule
